// File: rtl/cpu_pkg.sv
// Shared opcode constants and control FSM state encoding for the tiny CPU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  // Opcodes that write the register file in EXEC.
  function automatic logic is_rf_op(input logic [3:0] op);
    return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI};
  endfunction

  // Opcodes whose ALU result updates the zero flag.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

  // Opcodes that carry a second (immediate/target) byte.
  function automatic logic has_imm(input logic [3:0] op);
    return op inside {OP_LDI, OP_JMP, OP_JZ};
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 1- or 2-byte instructions, decodes inline,
// drives register-file/ALU controls in EXEC, and handles jumps and halt.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       zero_in,
  output logic [7:0] pc,
  output logic       rf_we,
  output logic [1:0] rf_rd,
  output logic [1:0] rf_rs,
  output logic [2:0] alu_op,
  output logic       wb_sel,
  output logic [7:0] imm,
  output logic       halted
);

  state_t     state, state_nxt;
  logic [7:0] ir, ir_nxt;
  logic [7:0] pc_nxt, imm_nxt;
  logic       z, z_nxt;
  logic [3:0] op;
  logic [7:0] pc_inc;

  assign op     = ir[7:4];
  assign pc_inc = pc + 8'd1;   // wraps 0xFF -> 0x00

  // State and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
      imm   <= 8'h00;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      imm   <= imm_nxt;
      z     <= z_nxt;
    end
  end

  // Next-state, register updates and control outputs (inline decoder).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    imm_nxt   = imm;
    z_nxt     = z;
    rf_we     = 1'b0;
    rf_rd     = 2'd0;
    rf_rs     = 2'd0;
    alu_op    = 3'd0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_nxt    = instr;
        pc_nxt    = pc_inc;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (has_imm(op))        state_nxt = S_IMM;
        else if (op == OP_HALT) state_nxt = S_HALT;
        else                    state_nxt = S_EXEC;   // includes NOP and A-E
      end
      S_IMM: begin
        state_nxt = S_FETCH;
        case (op)
          OP_LDI: begin
            imm_nxt   = instr;
            pc_nxt    = pc_inc;
            state_nxt = S_EXEC;
          end
          OP_JMP:  pc_nxt = instr;
          OP_JZ:   pc_nxt = z ? instr : pc_inc;   // skip the target byte when not taken
          default: pc_nxt = pc_inc;
        endcase
      end
      S_EXEC: begin
        // Write is suppressed combinationally in a reset cycle.
        rf_we  = is_rf_op(op) && !rst;
        rf_rd  = ir[3:2];
        rf_rs  = ir[1:0];
        wb_sel = (op == OP_LDI);
        if (is_rf_op(op) && op != OP_LDI) alu_op = ir[6:4];
        if (is_alu_op(op)) z_nxt = zero_in;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;   // hold everything until reset
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model checked every cycle,
// directed literal checks, then randomized programs with random resets.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr;
  logic       zero_in = 1'b0;
  logic [7:0] pc;
  logic       rf_we;
  logic [1:0] rf_rd, rf_rs;
  logic [2:0] alu_op;
  logic       wb_sel;
  logic [7:0] imm;
  logic       halted;

  logic [7:0] mem [256];
  int n_tests = 0;
  int n_fail  = 0;
  bit zrand   = 1'b0;

  assign instr = mem[pc];

  control_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .zero_in(zero_in),
    .pc(pc), .rf_we(rf_we), .rf_rd(rf_rd), .rf_rs(rf_rs),
    .alu_op(alu_op), .wb_sel(wb_sel), .imm(imm), .halted(halted)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: pc at instruction start, z, imm, plus the cycle index
  // within the current instruction (latency: LDI 4, HALT unbounded, else 3).
  logic [7:0] m_pc = 8'h00, m_imm = 8'h00, cur = 8'h00;
  logic [7:0] p1, p2, epc;
  logic [3:0] mop;
  bit         m_z = 1'b0, pend = 1'b1, ehalt, ewe;
  int         k = 0, lat;

  always @(negedge clk) begin
    if (rst) begin
      chk("we_in_reset_cycle", 8'(rf_we), 8'h00);
      pend = 1'b1;
    end else begin
      if (pend) begin
        m_pc = 8'h00; m_z = 1'b0; m_imm = 8'h00; k = 0; pend = 1'b0;
      end
      p1 = m_pc + 8'd1;
      p2 = m_pc + 8'd2;
      if (k == 0) cur = mem[m_pc];
      mop   = cur[7:4];
      lat   = (mop == 4'h7) ? 4 : 3;
      epc   = (k == 0) ? m_pc : ((k == 3 && mop == 4'h7) ? p2 : p1);
      ehalt = (mop == 4'hF) && (k >= 2);
      ewe   = (mop >= 4'd1 && mop <= 4'd7) && (k == lat - 1);
      if (mop == 4'h7 && k == 3) m_imm = mem[p1];
      chk("pc", pc, epc);
      chk("rf_we", 8'(rf_we), 8'(ewe));
      chk("halted", 8'(halted), 8'(ehalt));
      chk("imm", imm, m_imm);
      if (ewe) begin
        chk("rf_rd", 8'(rf_rd), 8'(cur[3:2]));
        chk("rf_rs", 8'(rf_rs), 8'(cur[1:0]));
        chk("wb_sel", 8'(wb_sel), 8'(mop == 4'h7));
        if (mop <= 4'd6) chk("alu_op", 8'(alu_op), 8'(mop[2:0]));
      end
      if (mop != 4'hF && k == lat - 1) begin
        if (mop >= 4'd2 && mop <= 4'd6) m_z = zero_in;
        case (mop)
          4'h7:    m_pc = p2;
          4'h8:    m_pc = mem[p1];
          4'h9:    m_pc = m_z ? mem[p1] : p2;
          default: m_pc = p1;
        endcase
        k = 0;
      end else if (k < 3) begin
        k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial forever begin
    @(posedge clk); #1;
    if (zrand) zero_in = 1'($urandom_range(0, 1));
  end

  task automatic rst_on();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic rst_off();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic clr_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit         we_seen;
    logic [7:0] b;
    clr_mem();

    // LDI R1,5 ; ADD R1,R2 ; HALT
    rst_on(); clr_mem();
    mem[0] = 8'h74; mem[1] = 8'h05; mem[2] = 8'h26; mem[3] = 8'hF0;
    rst_off();
    cyc(1);
    chk("reset_pc", pc, 8'h00);
    chk("reset_we", 8'(rf_we), 8'h00);
    chk("reset_halted", 8'(halted), 8'h00);
    chk("reset_imm", imm, 8'h00);
    cyc(3);
    chk("ldi_we", 8'(rf_we), 8'h01);
    chk("ldi_rd", 8'(rf_rd), 8'h01);
    chk("ldi_wbsel", 8'(wb_sel), 8'h01);
    chk("ldi_imm", imm, 8'h05);
    chk("ldi_pc", pc, 8'h02);
    cyc(3);
    chk("add_we", 8'(rf_we), 8'h01);
    chk("add_rd", 8'(rf_rd), 8'h01);
    chk("add_rs", 8'(rf_rs), 8'h02);
    chk("add_aluop", 8'(alu_op), 8'h02);
    chk("add_wbsel", 8'(wb_sel), 8'h00);
    cyc(1);
    chk("add_we_one_cycle", 8'(rf_we), 8'h00);
    cyc(2);
    chk("halt_flag", 8'(halted), 8'h01);
    chk("halt_pc", pc, 8'h04);
    cyc(10);
    chk("halt_flag_held", 8'(halted), 8'h01);
    chk("halt_pc_held", pc, 8'h04);
    chk("halt_we", 8'(rf_we), 8'h00);

    // JMP 0x10
    rst_on(); clr_mem();
    mem[0] = 8'h80; mem[1] = 8'h10; mem[8'h10] = 8'hF0;
    rst_off();
    we_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rf_we) we_seen = 1'b1;
    end
    chk("jmp_no_write", 8'(we_seen), 8'h00);
    cyc(1);
    chk("jmp_pc", pc, 8'h10);

    // SUB sets z, then JZ 0x20: taken with zero_in=1, falls through with 0
    for (int t = 0; t < 2; t++) begin
      rst_on(); clr_mem();
      mem[0] = 8'h35; mem[1] = 8'h90; mem[2] = 8'h20; mem[3] = 8'hF0; mem[8'h20] = 8'hF0;
      zero_in = (t == 0);
      rst_off();
      cyc(7);
      chk(t == 0 ? "jz_taken_pc" : "jz_not_taken_pc", pc, t == 0 ? 8'h20 : 8'h03);
    end

    // LDI at 0xFF, immediate wraps to 0x00
    rst_on(); clr_mem();
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'h70;
    rst_off();
    cyc(7);
    chk("wrap_imm", imm, 8'h80);
    chk("wrap_pc", pc, 8'h01);
    chk("wrap_we", 8'(rf_we), 8'h01);

    // Reset during LDI EXEC
    rst_on(); clr_mem();
    mem[0] = 8'h74; mem[1] = 8'h05;
    rst_off();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1);
    chk("midexec_rst_we", 8'(rf_we), 8'h00);
    @(posedge clk); #1 rst = 1'b0;
    cyc(1);
    chk("midexec_rst_pc", pc, 8'h00);
    chk("midexec_rst_imm", imm, 8'h00);
    cyc(1);
    chk("midexec_fetch_pc", pc, 8'h01);

    // Randomized programs; HALT allowed only in the last round
    zrand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rst_on();
      for (int a = 0; a < 256; a++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hF && r < 5) b[7:4] = 4'($urandom_range(0, 14));
        mem[a] = b;
      end
      rst_off();
      repeat (1500) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 299) == 0) begin
          rst = 1'b1;
          @(posedge clk); #1 rst = 1'b0;
        end
      end
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
